// File: rtl/bram_port_arbiter_pkg.sv
// Shared definitions for the image BRAM port arbiter: requester indices,
// read-tag layout, arbiter FSM encoding and small index/one-hot helpers.
// Latency: n/a (package). Backpressure: n/a.
package bram_port_arbiter_pkg;

  localparam int NREQ  = 3;
  localparam int IDX_W = 2;

  localparam logic [IDX_W-1:0] REQ_LOAD = 2'd0;  // AXI-Stream loader
  localparam logic [IDX_W-1:0] REQ_DWT  = 2'd1;  // DWT engine
  localparam logic [IDX_W-1:0] REQ_COMP = 2'd2;  // compression engine

  // Read-latency tag carried alongside each issued read.
  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } tag_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_t;

  // Round-robin successor, wrapping the last requester back to the first.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == REQ_COMP) ? REQ_LOAD : i + 2'd1;
  endfunction

  function automatic logic [NREQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] i);
    logic [NREQ-1:0] oh;
    oh    = '0;
    oh[i] = 1'b1;
    return oh;
  endfunction

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    case (oh)
      3'b010:  idx = REQ_DWT;
      3'b100:  idx = REQ_COMP;
      default: idx = REQ_LOAD;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_arb.sv
// Round-robin arbiter with burst hold for one BRAM port (three requesters).
// Latency: grant is combinational from req and current owner/burst state.
// Backpressure: a requester is stalled simply by not being granted; owner keeps
//   the port for up to MAX_BURST grants while others wait, then yields.
// Ports: clk, rst (async active-low), req[2:0] in; gnt[2:0] one-hot out,
//   gnt_idx = index of the granted requester (meaningful only when |gnt).
module rr_burst_arb
  import bram_port_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic [NREQ-1:0]  gnt_c;

  // Search orders: from the rr pointer (idle) and after the owner (handover).
  logic [IDX_W-1:0] p1, p2, o1, o2;
  logic             others;

  assign p1     = next_idx(ptr_q);
  assign p2     = next_idx(p1);
  assign o1     = next_idx(owner_q);
  assign o2     = next_idx(o1);
  assign others = |(req & ~idx_to_onehot(owner_q));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;
    gnt_c   = '0;
    case (state_q)
      ARB_IDLE: begin
        burst_d = '0;
        if (req[ptr_q]) begin
          state_d = ARB_OWN;
          owner_d = ptr_q;
        end else if (req[p1]) begin
          state_d = ARB_OWN;
          owner_d = p1;
        end else if (req[p2]) begin
          state_d = ARB_OWN;
          owner_d = p2;
        end
        if (state_d == ARB_OWN) gnt_c = idx_to_onehot(owner_d);
      end
      ARB_OWN: begin
        if (req[owner_q] && ((burst_q < BURST_LAST) || !others)) begin
          gnt_c = idx_to_onehot(owner_q);
          if (burst_q != BURST_LAST) burst_d = burst_q + CNT_W'(1);
        end else begin
          // Release: owner dropped its request or used up its burst while
          // someone else waits. Hand over in the same cycle if possible.
          ptr_d   = o1;
          burst_d = '0;
          if (req[o1]) begin
            owner_d = o1;
            gnt_c   = idx_to_onehot(o1);
          end else if (req[o2]) begin
            owner_d = o2;
            gnt_c   = idx_to_onehot(o2);
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Grant is forced low while reset is asserted so no transfer is seen then.
  assign gnt     = rst ? gnt_c : '0;
  assign gnt_idx = owner_d;

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one simple-dual-port image BRAM (A write, B read) between loader,
// DWT and compression engines; routes read data back by latency tag.
// Latency: grant comb; write commits 1 edge after grant; read data 2 cycles
//   after grant, one read per cycle sustained.
// Backpressure: non-granted requesters hold req/address until granted.
// Ports: clk, rst (async active-low); rd_req/rd_addr -> rd_gnt, rd_valid,
//   rd_data; wr_req/wr_addr/wr_data -> wr_gnt; BRAM pins addra/dina/wea,
//   addrb, doutb.
// Option: define BRAM_ARB_RAW_FWD_EN for write-first forwarding on a
//   same-cycle read/write address match (default read-first).
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 10,
  parameter int MAX_BURST = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          rd_req,
  input  logic [NREQ*ADDR_W-1:0]   rd_addr,
  output logic [NREQ-1:0]          rd_gnt,
  output logic [NREQ-1:0]          rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  input  logic [NREQ-1:0]          wr_req,
  input  logic [NREQ*ADDR_W-1:0]   wr_addr,
  input  logic [NREQ*DATA_W-1:0]   wr_data,
  output logic [NREQ-1:0]          wr_gnt,
  output logic [ADDR_W-1:0]        addra,
  output logic [DATA_W-1:0]        dina,
  output logic                     wea,
  output logic [ADDR_W-1:0]        addrb,
  input  logic [DATA_W-1:0]        doutb
);

  logic [IDX_W-1:0] rd_idx, wr_idx;

  rr_burst_arb #(.MAX_BURST(MAX_BURST)) u_rd_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (rd_req),
    .gnt     (rd_gnt),
    .gnt_idx (rd_idx)
  );

  rr_burst_arb #(.MAX_BURST(MAX_BURST)) u_wr_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (wr_req),
    .gnt     (wr_gnt),
    .gnt_idx (wr_idx)
  );

  // Port A: register the winner; address/data hold when nothing is written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addra <= '0;
      dina  <= '0;
      wea   <= 1'b0;
    end else if (|wr_gnt) begin
      addra <= wr_addr[wr_idx*ADDR_W +: ADDR_W];
      dina  <= wr_data[wr_idx*DATA_W +: DATA_W];
      wea   <= 1'b1;
    end else begin
      wea   <= 1'b0;
    end
  end

  // Port B: stage 1 = address registered onto the BRAM, stage 2 = BRAM
  // output register valid. The tag follows the address through both.
  tag_t tag_s1, tag_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addrb  <= '0;
      tag_s1 <= '0;
      tag_s2 <= '0;
    end else begin
      if (|rd_gnt) addrb <= rd_addr[rd_idx*ADDR_W +: ADDR_W];
      tag_s1.vld <= |rd_gnt;
      tag_s1.idx <= (|rd_gnt) ? rd_idx : '0;
      tag_s2     <= tag_s1;
    end
  end

  logic [DATA_W-1:0] rd_sel;

`ifdef BRAM_ARB_RAW_FWD_EN
  // A read and write hitting the same address in the same BRAM cycle: the
  // BRAM itself is read-first, so substitute the written word at stage 2.
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_dat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_hit <= 1'b0;
      fwd_dat <= '0;
    end else begin
      fwd_hit <= tag_s1.vld && wea && (addra == addrb);
      fwd_dat <= dina;
    end
  end

  assign rd_sel = fwd_hit ? fwd_dat : doutb;
`else
  assign rd_sel = doutb;
`endif

  assign rd_valid = tag_s2.vld ? idx_to_onehot(tag_s2.idx) : '0;
  assign rd_data  = tag_s2.vld ? rd_sel : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
module tb_bram_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    rd_req, rd_gnt, rd_valid, wr_req, wr_gnt;
  logic [3*AW-1:0] rd_addr, wr_addr;
  logic [3*DW-1:0] wr_data;
  logic [DW-1:0] rd_data, dina, doutb;
  logic [AW-1:0] addra, addrb;
  logic          wea;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [0:4095];

  always #5 clk = ~clk;

  // Behavioural read-first simple-dual-port BRAM with registered output.
  always @(posedge clk) begin
    if (wea) mem[addra] <= dina;
    doutb <= mem[addrb];
  end

  bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(8)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .addra(addra), .dina(dina), .wea(wea), .addrb(addrb), .doutb(doutb)
  );

  function automatic logic [DW-1:0] pat(input int i);
    return DW'((i * 37) ^ 'h155);
  endfunction

  task automatic idle_inputs();
    rd_req = '0; wr_req = '0; rd_addr = '0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    rd_req = 3'b111; wr_req = 3'b111;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (rd_gnt !== 3'b000) begin errors++; $display("FAIL reset_rd_gnt: got %b want 000", rd_gnt); end
    checks++; if (wr_gnt !== 3'b000) begin errors++; $display("FAIL reset_wr_gnt: got %b want 000", wr_gnt); end
    checks++; if (rd_valid !== 3'b000) begin errors++; $display("FAIL reset_rd_valid: got %b want 000", rd_valid); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h want 000", rd_data); end
    checks++; if ({wea, addra, dina, addrb} !== '0) begin errors++;
      $display("FAIL reset_bram_pins: got wea=%b addra=%h dina=%h addrb=%h want all 0", wea, addra, dina, addrb); end
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    mem[5] = 10'h1A3;
    @(negedge clk); rd_req = 3'b010; rd_addr[1*AW +: AW] = 12'h005; #1;
    checks++; if (rd_gnt !== 3'b010) begin errors++; $display("FAIL single_gnt: got %b want 010", rd_gnt); end
    @(negedge clk); rd_req = 3'b000; #1;
    checks++; if (addrb !== 12'h005) begin errors++; $display("FAIL single_addrb: got %h want 005", addrb); end
    checks++; if (rd_valid !== 3'b000) begin errors++; $display("FAIL single_early_valid: got %b want 000", rd_valid); end
    @(negedge clk); #1;
    checks++; if (rd_valid !== 3'b010) begin errors++; $display("FAIL single_valid: got %b want 010", rd_valid); end
    checks++; if (rd_data !== 10'h1A3) begin errors++; $display("FAIL single_data: got %h want 1a3", rd_data); end
    @(negedge clk); #1;
    checks++; if (rd_valid !== 3'b000 || rd_data !== '0) begin errors++;
      $display("FAIL single_after: got valid=%b data=%h want 000/000", rd_valid, rd_data); end
  endtask

  task automatic test_contention();
    int multi = 0;
    logic [2:0] exp;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); rd_req = 3'b111; #1;
      exp = (i < 8) ? 3'b001 : (i < 16) ? 3'b010 : (i < 24) ? 3'b100 : 3'b001;
      checks++; if (rd_gnt !== exp) begin errors++; $display("FAIL contention_gnt[%0d]: got %b want %b", i, rd_gnt, exp); end
      if ($countones(rd_gnt) > 1) multi++;
    end
    checks++; if (multi !== 0) begin errors++; $display("FAIL contention_onehot: got %0d multi-grant cycles want 0", multi); end
    @(negedge clk); rd_req = 3'b000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_owner_release();
    logic [2:0] reqs [6];
    logic [2:0] exps [6];
    reqs = '{3'b010, 3'b011, 3'b011, 3'b001, 3'b000, 3'b101};
    exps = '{3'b010, 3'b010, 3'b010, 3'b001, 3'b000, 3'b100};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); rd_req = reqs[i]; #1;
      checks++; if (rd_gnt !== exps[i]) begin errors++; $display("FAIL release_gnt[%0d]: got %b want %b", i, rd_gnt, exps[i]); end
    end
    @(negedge clk); rd_req = 3'b000;
  endtask

  task automatic test_collision();
    logic [DW-1:0] exp;
`ifdef BRAM_ARB_RAW_FWD_EN
    exp = 10'h2AA;
`else
    exp = 10'h010;
`endif
    do_reset();
    mem[12'h0FF] = 10'h010;
    @(negedge clk);
    wr_req = 3'b001; wr_addr[0 +: AW] = 12'h0FF; wr_data[0 +: DW] = 10'h2AA;
    rd_req = 3'b100; rd_addr[2*AW +: AW] = 12'h0FF;
    #1;
    checks++; if (wr_gnt !== 3'b001 || rd_gnt !== 3'b100) begin errors++;
      $display("FAIL coll_gnt: got wr=%b rd=%b want 001/100", wr_gnt, rd_gnt); end
    @(negedge clk); wr_req = 3'b000; rd_req = 3'b000; #1;
    checks++; if ({wea, addra, dina, addrb} !== {1'b1, 12'h0FF, 10'h2AA, 12'h0FF}) begin errors++;
      $display("FAIL coll_pins: got wea=%b addra=%h dina=%h addrb=%h want 1/0ff/2aa/0ff", wea, addra, dina, addrb); end
    @(negedge clk); #1;
    checks++; if (rd_valid !== 3'b100) begin errors++; $display("FAIL coll_valid: got %b want 100", rd_valid); end
    checks++; if (rd_data !== exp) begin errors++; $display("FAIL coll_data: got %h want %h", rd_data, exp); end
    checks++; if (mem[12'h0FF] !== 10'h2AA) begin errors++; $display("FAIL coll_mem: got %h want 2aa", mem[12'h0FF]); end
    checks++; if (wea !== 1'b0) begin errors++; $display("FAIL coll_wea_drop: got %b want 0", wea); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 4; k++) mem[12'h100 + k] = DW'(10'h300 + k * 7);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 4) begin rd_req = 3'b001; rd_addr[0 +: AW] = AW'(12'h100 + i); end
      else rd_req = 3'b000;
      #1;
      if (i < 4) begin
        checks++; if (rd_gnt !== 3'b001) begin errors++; $display("FAIL b2b_gnt[%0d]: got %b want 001", i, rd_gnt); end
      end
      if (i >= 2) begin
        checks++; if (rd_valid !== 3'b001 || rd_data !== DW'(10'h300 + (i - 2) * 7)) begin errors++;
          $display("FAIL b2b_data[%0d]: got valid=%b data=%h want 001/%h", i, rd_valid, rd_data, DW'(10'h300 + (i - 2) * 7)); end
      end
    end
  endtask

  task automatic test_loader();
    int bad = 0;
    int wea_cnt = 0;
    do_reset();
    for (int i = 0; i <= 4097; i++) begin
      @(negedge clk);
      if (i < 4096) begin
        wr_req = 3'b001; wr_addr[0 +: AW] = AW'(i); wr_data[0 +: DW] = pat(i);
      end else wr_req = 3'b000;
      #1;
      if (i < 4096 && wr_gnt !== 3'b001) bad++;
      if (wea === 1'b1) wea_cnt++;
      if (i >= 1 && i <= 4096 && (wea !== 1'b1 || addra !== AW'(i - 1) || dina !== pat(i - 1))) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL load_stream: got %0d bad cycles want 0", bad); end
    checks++; if (wea_cnt !== 4096) begin errors++; $display("FAIL load_wea_count: got %0d want 4096", wea_cnt); end
    checks++; if (wea !== 1'b0 || addra !== 12'hFFF || dina !== pat(4095)) begin errors++;
      $display("FAIL load_hold: got wea=%b addra=%h dina=%h want 0/fff/%h", wea, addra, dina, pat(4095)); end
    checks++; if (mem[12'hFFF] !== pat(4095) || mem[12'h000] !== pat(0) || mem[12'h800] !== pat(2048)) begin errors++;
      $display("FAIL load_mem: got fff=%h 000=%h 800=%h want %h/%h/%h", mem[12'hFFF], mem[12'h000], mem[12'h800], pat(4095), pat(0), pat(2048)); end
  endtask

  task automatic test_reset_inflight();
    int stale = 0;
    do_reset();
    mem[12'h020] = 10'h111; mem[12'h021] = 10'h222;
    @(negedge clk); rd_req = 3'b001; rd_addr[0 +: AW] = 12'h020;
    @(negedge clk); rd_addr[0 +: AW] = 12'h021;
    @(negedge clk); rd_req = 3'b000; rst = 1'b0; #1;
    checks++; if ({rd_valid, rd_data, rd_gnt, wr_gnt, wea, addra, dina, addrb} !== '0) begin errors++;
      $display("FAIL rst_mid_outputs: got valid=%b data=%h addrb=%h want all 0", rd_valid, rd_data, addrb); end
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; if (rd_valid !== 3'b000) stale++;
      @(negedge clk);
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL rst_mid_stale: got %0d stale valid cycles want 0", stale); end
    rd_req = 3'b111; #1;
    checks++; if (rd_gnt !== 3'b001) begin errors++; $display("FAIL rst_mid_first_gnt: got %b want 001", rd_gnt); end
    @(negedge clk); rd_req = 3'b000;
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = '0;
    test_reset();
    test_single_read();
    test_contention();
    test_owner_release();
    test_collision();
    test_back_to_back();
    test_loader();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
